// File: rtl/rpn_digit_entry.sv
// Operand entry for the 8-bit RPN calculator: accumulates dec/hex/oct keystrokes
// into a binary operand, flags bad digits and overflow, and hands it to the stack.
module rpn_digit_entry #(
    parameter int MAX_DEC = 3,
    parameter int MAX_HEX = 2,
    parameter int MAX_OCT = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] Base,
    input  logic [3:0] Digito,
    input  logic       DigitoValido,
    input  logic       Enter,
    input  logic       Limpar,
    output logic [7:0] Operando,
    output logic       OperandoValido,
    output logic [7:0] Acumulado,
    output logic [1:0] NumDigitos,
    output logic       Erro
);

    typedef enum logic [1:0] {VAZIO, ENTRADA, ERRO} state_t;

    state_t      state;
    logic [1:0]  base_q;
    logic [4:0]  radix_use;
    logic [11:0] next_val;
    logic        digit_ok;
    logic        at_max;

    function automatic logic [4:0] radix_of(input logic [1:0] b);
        case (b)
            2'b01:   return 5'd16;
            2'b10:   return 5'd8;
            default: return 5'd10;
        endcase
    endfunction

    function automatic logic [1:0] max_of(input logic [1:0] b);
        case (b)
            2'b01:   return 2'(MAX_HEX);
            2'b10:   return 2'(MAX_OCT);
            default: return 2'(MAX_DEC);
        endcase
    endfunction

    // The first digit of an entry is judged against the live Base switch;
    // later digits against the base latched with that first digit.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        radix_use = (state == ENTRADA) ? radix_of(base_q) : radix_of(Base);
        digit_ok  = ({1'b0, Digito} < radix_use);
        next_val  = 12'(Acumulado) * 12'(radix_use) + 12'(Digito);
        at_max    = (NumDigitos == max_of(base_q));
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            // NOTE: non-blocking assignments for all registered state avoid read/write races between blocks.
            state          <= VAZIO;
            base_q         <= 2'b00;
            Operando       <= 8'd0;
            OperandoValido <= 1'b0;
            Acumulado      <= 8'd0;
            NumDigitos     <= 2'd0;
            Erro           <= 1'b0;
        end else begin
            OperandoValido <= 1'b0;
            case (state)
                VAZIO: begin
                    if (!Limpar && !Enter && DigitoValido) begin
                        if (digit_ok) begin
                            Acumulado  <= {4'd0, Digito};
                            NumDigitos <= 2'd1;
                            base_q     <= Base;
                            state      <= ENTRADA;
                        end else begin
                            state <= ERRO;
                            Erro  <= 1'b1;
                        end
                    end
                end
                ENTRADA: begin
                    if (Limpar) begin
                        Acumulado  <= 8'd0;
                        NumDigitos <= 2'd0;
                        state      <= VAZIO;
                    end else if (Enter) begin
                        Operando       <= Acumulado;
                        OperandoValido <= 1'b1;
                        Acumulado      <= 8'd0;
                        NumDigitos     <= 2'd0;
                        state          <= VAZIO;
                    end else if (DigitoValido) begin
                        if (!digit_ok || (!at_max && next_val > 12'd255)) begin
                            state <= ERRO;
                            Erro  <= 1'b1;
                        end else if (!at_max) begin
                            Acumulado  <= next_val[7:0];
                            NumDigitos <= NumDigitos + 2'd1;
                        end
                    end
                end
                ERRO: begin
                    if (Limpar) begin
                        Acumulado  <= 8'd0;
                        NumDigitos <= 2'd0;
                        Erro       <= 1'b0;
                        state      <= VAZIO;
                    end
                end
                default: state <= VAZIO;
            endcase
        end
    end

endmodule
